// File: rtl/id_alu_issue.sv
// RV64I decode/issue stage: decodes one instruction bundle into ALU operands and
// control, and holds it in a single registered output slot toward execute.

package cpu_consts;
   localparam int unsigned XLEN = 64;
   localparam int unsigned FW   = 4;

   localparam logic [FW-1:0] OP_ADD  = 4'd0;
   localparam logic [FW-1:0] OP_SUB  = 4'd1;
   localparam logic [FW-1:0] OP_SLL  = 4'd2;
   localparam logic [FW-1:0] OP_SRL  = 4'd3;
   localparam logic [FW-1:0] OP_SRA  = 4'd4;
   localparam logic [FW-1:0] OP_OR   = 4'd5;
   localparam logic [FW-1:0] OP_AND  = 4'd6;
   localparam logic [FW-1:0] OP_XOR  = 4'd7;
   localparam logic [FW-1:0] OP_SLTU = 4'd8;
   localparam logic [FW-1:0] OP_SLT  = 4'd9;

   localparam logic [1:0] MEM_NONE  = 2'b00;
   localparam logic [1:0] MEM_LOAD  = 2'b01;
   localparam logic [1:0] MEM_STORE = 2'b10;

   // Payload of the issue slot.
   typedef struct packed {
      logic [XLEN-1:0] opr_a;
      logic [XLEN-1:0] opr_b;
      logic [FW-1:0]   alu_func;
      logic [4:0]      rd;
      logic            rd_we;
      logic [XLEN-1:0] store_data;
      logic [1:0]      mem_op;
      logic            br;
      logic [2:0]      br_f3;
      logic            jmp;
      logic [XLEN-1:0] tgt;
      logic            illegal;
   } issue_t;
endpackage

module id_alu_issue
   import cpu_consts::*;
(
   input  logic            clk_i,
   input  logic            resetn_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [31:0]     instr_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic            flush_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] opr_a_o,
   output logic [XLEN-1:0] opr_b_o,
   output logic [FW-1:0]   alu_func_o,
   output logic [4:0]      rd_o,
   output logic            rd_we_o,
   output logic [XLEN-1:0] store_data_o,
   output logic [1:0]      mem_op_o,
   output logic            br_o,
   output logic [2:0]      br_f3_o,
   output logic            jmp_o,
   output logic [XLEN-1:0] tgt_o,
   output logic            illegal_o
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [5:0] F6_BASE = 6'b000000;
   localparam logic [5:0] F6_ALT  = 6'b010000;

   logic [6:0]      opcode;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [5:0]      f6;
   logic [4:0]      rd_fld;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   logic            load_c;
   logic            ok;
   logic            wr;
   issue_t          dec;
   issue_t          issue_d, issue_q;
   logic            valid_d, valid_q;

   assign opcode = instr_i[6:0];
   assign rd_fld = instr_i[11:7];
   assign f3     = instr_i[14:12];
   assign f7     = instr_i[31:25];
   assign f6     = instr_i[31:26];

   assign imm_i = {{52{instr_i[31]}}, instr_i[31:20]};
   assign imm_s = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
   assign imm_b = {{51{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                   instr_i[11:8], 1'b0};
   assign imm_u = {{32{instr_i[31]}}, instr_i[31:12], 12'h000};
   assign imm_j = {{43{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                   instr_i[30:21], 1'b0};

   // funct3 -> ALU function for the non-shift, non-add/sub register ops.
   function automatic logic [FW-1:0] f3_func(input logic [2:0] f);
      logic [FW-1:0] r;
      r = OP_ADD;
      case (f)
         3'b001:  r = OP_SLL;
         3'b010:  r = OP_SLT;
         3'b011:  r = OP_SLTU;
         3'b100:  r = OP_XOR;
         3'b101:  r = OP_SRL;
         3'b110:  r = OP_OR;
         3'b111:  r = OP_AND;
         default: r = OP_ADD;
      endcase
      return r;
   endfunction

   // Instruction decode; an undecodable word collapses to the clean illegal bundle.
   always_comb begin
      dec          = '0;
      dec.alu_func = OP_ADD;
      ok           = 1'b1;
      wr           = 1'b0;
      issue_d      = '0;
      case (opcode)
         OPC_OP: begin
            dec.opr_a = rs1_data_i;
            dec.opr_b = rs2_data_i;
            wr        = 1'b1;
            case (f3)
               3'b000: begin
                  if (f7 == F7_BASE)     dec.alu_func = OP_ADD;
                  else if (f7 == F7_ALT) dec.alu_func = OP_SUB;
                  else                   ok = 1'b0;
               end
               3'b101: begin
                  if (f7 == F7_BASE)     dec.alu_func = OP_SRL;
                  else if (f7 == F7_ALT) dec.alu_func = OP_SRA;
                  else                   ok = 1'b0;
               end
               default: begin
                  dec.alu_func = f3_func(f3);
                  if (f7 != F7_BASE) ok = 1'b0;
               end
            endcase
         end
         OPC_OPIMM: begin
            dec.opr_a = rs1_data_i;
            dec.opr_b = imm_i;
            wr        = 1'b1;
            case (f3)
               3'b001: begin
                  dec.opr_b    = {58'h0, instr_i[25:20]};
                  dec.alu_func = OP_SLL;
                  if (f6 != F6_BASE) ok = 1'b0;
               end
               3'b101: begin
                  dec.opr_b = {58'h0, instr_i[25:20]};
                  if (f6 == F6_BASE)     dec.alu_func = OP_SRL;
                  else if (f6 == F6_ALT) dec.alu_func = OP_SRA;
                  else                   ok = 1'b0;
               end
               default: dec.alu_func = f3_func(f3);
            endcase
         end
         OPC_LUI: begin
            dec.opr_b = imm_u;
            wr        = 1'b1;
         end
         OPC_AUIPC: begin
            dec.opr_a = pc_i;
            dec.opr_b = imm_u;
            wr        = 1'b1;
         end
         OPC_LOAD: begin
            dec.opr_a  = rs1_data_i;
            dec.opr_b  = imm_i;
            dec.mem_op = MEM_LOAD;
            wr         = 1'b1;
            if (f3 == 3'b111) ok = 1'b0;
         end
         OPC_STORE: begin
            dec.opr_a      = rs1_data_i;
            dec.opr_b      = imm_s;
            dec.mem_op     = MEM_STORE;
            dec.store_data = rs2_data_i;
            if (f3[2]) ok = 1'b0;
         end
         OPC_BRANCH: begin
            dec.opr_a = rs1_data_i;
            dec.opr_b = rs2_data_i;
            dec.br    = 1'b1;
            dec.br_f3 = f3;
            dec.tgt   = pc_i + imm_b;
            case (f3)
               3'b000, 3'b001: dec.alu_func = OP_SUB;
               3'b100, 3'b101: dec.alu_func = OP_SLT;
               3'b110, 3'b111: dec.alu_func = OP_SLTU;
               default:        ok = 1'b0;
            endcase
         end
         OPC_JAL: begin
            dec.opr_a = pc_i;
            dec.opr_b = 64'd4;
            dec.jmp   = 1'b1;
            dec.tgt   = pc_i + imm_j;
            wr        = 1'b1;
         end
         OPC_JALR: begin
            dec.opr_a = pc_i;
            dec.opr_b = 64'd4;
            dec.jmp   = 1'b1;
            dec.tgt   = (rs1_data_i + imm_i) & ~64'h1;
            wr        = 1'b1;
            if (f3 != 3'b000) ok = 1'b0;
         end
         default: ok = 1'b0;
      endcase

      dec.rd    = wr ? rd_fld : 5'd0;
      dec.rd_we = wr && (rd_fld != 5'd0);

      if (ok) begin
         issue_d = dec;
      end else begin
         issue_d          = '0;
         issue_d.alu_func = OP_ADD;
         issue_d.illegal  = 1'b1;
      end
   end

   assign in_ready_o = !valid_q || out_ready_i;
   assign load_c     = in_valid_i && in_ready_o && !flush_i;

   // Slot control: flush beats load, load beats consume.
   always_comb begin
      valid_d = valid_q;
      if (flush_i)                        valid_d = 1'b0;
      else if (load_c)                    valid_d = 1'b1;
      else if (valid_q && out_ready_i)    valid_d = 1'b0;
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         valid_q          <= 1'b0;
         issue_q          <= '0;
         issue_q.alu_func <= OP_ADD;
      end else begin
         valid_q <= valid_d;
         if (load_c) issue_q <= issue_d;
      end
   end

   assign out_valid_o  = valid_q;
   assign opr_a_o      = issue_q.opr_a;
   assign opr_b_o      = issue_q.opr_b;
   assign alu_func_o   = issue_q.alu_func;
   assign rd_o         = issue_q.rd;
   assign rd_we_o      = issue_q.rd_we;
   assign store_data_o = issue_q.store_data;
   assign mem_op_o     = issue_q.mem_op;
   assign br_o         = issue_q.br;
   assign br_f3_o      = issue_q.br_f3;
   assign jmp_o        = issue_q.jmp;
   assign tgt_o        = issue_q.tgt;
   assign illegal_o    = issue_q.illegal;

endmodule

// File: tb/tb_id_alu_issue.sv
// Directed bench for id_alu_issue with hand-encoded RV64I words and expected decodes.

module tb_id_alu_issue;
   import cpu_consts::*;

   logic        clk = 1'b0;
   logic        resetn;
   logic        in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] instr;
   logic [63:0] pc, rs1, rs2;
   logic [63:0] opr_a, opr_b, store_data, tgt;
   logic [3:0]  alu_func;
   logic [4:0]  rd;
   logic        rd_we, br, jmp, illegal;
   logic [1:0]  mem_op;
   logic [2:0]  br_f3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_alu_issue dut (
      .clk_i        (clk),
      .resetn_i     (resetn),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .instr_i      (instr),
      .pc_i         (pc),
      .rs1_data_i   (rs1),
      .rs2_data_i   (rs2),
      .flush_i      (flush),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .opr_a_o      (opr_a),
      .opr_b_o      (opr_b),
      .alu_func_o   (alu_func),
      .rd_o         (rd),
      .rd_we_o      (rd_we),
      .store_data_o (store_data),
      .mem_op_o     (mem_op),
      .br_o         (br),
      .br_f3_o      (br_f3),
      .jmp_o        (jmp),
      .tgt_o        (tgt),
      .illegal_o    (illegal)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] w, input logic [63:0] p,
                        input logic [63:0] a, input logic [63:0] b);
      instr = w; pc = p; rs1 = a; rs2 = b;
   endtask

   initial begin
      resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      drive(32'h0, 64'h0, 64'h0, 64'h0);
      #12;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_a",     opr_a, 64'd0);
      chk("rst_func",  64'(alu_func), 64'(OP_ADD));
      chk("rst_tgt",   tgt, 64'd0);

      // ADDI x1,x2,-1 accepted on the first edge after reset release
      resetn = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      drive(32'hFFF10093, 64'h0, 64'd5, 64'd0);
      step();
      chk("addi_valid", 64'(out_valid), 64'd1);
      chk("addi_a",     opr_a, 64'd5);
      chk("addi_b",     opr_b, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("addi_func",  64'(alu_func), 64'(OP_ADD));
      chk("addi_rd",    64'(rd), 64'd1);
      chk("addi_we",    64'(rd_we), 64'd1);

      // SUB x3,x1,x2 then a 3-cycle stall with LUI waiting
      drive(32'h402081B3, 64'h0, 64'd10, 64'd3);
      step();
      chk("sub_func", 64'(alu_func), 64'(OP_SUB));
      chk("sub_b",    opr_b, 64'd3);
      chk("sub_rd",   64'(rd), 64'd3);
      out_ready = 1'b0;
      drive(32'h123452B7, 64'h0, 64'hAAAA, 64'hBBBB);
      #1;
      chk("stall_ready", 64'(in_ready), 64'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_valid", 64'(out_valid), 64'd1);
         chk("stall_a",     opr_a, 64'd10);
         chk("stall_func",  64'(alu_func), 64'(OP_SUB));
         chk("stall_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("unstall_ready", 64'(in_ready), 64'd1);
      step();
      chk("lui_valid", 64'(out_valid), 64'd1);
      chk("lui_a",     opr_a, 64'd0);
      chk("lui_b",     opr_b, 64'h0000_0000_1234_5000);
      chk("lui_rd",    64'(rd), 64'd5);

      drive(32'h800002B7, 64'h0, 64'h0, 64'h0);
      step();
      chk("lui_neg_b", opr_b, 64'hFFFF_FFFF_8000_0000);

      // BLT x1,x2,-8 at pc 0x1000
      drive(32'hFE20CCE3, 64'h1000, 64'd7, 64'd9);
      step();
      chk("blt_br",   64'(br), 64'd1);
      chk("blt_f3",   64'(br_f3), 64'd4);
      chk("blt_func", 64'(alu_func), 64'(OP_SLT));
      chk("blt_tgt",  tgt, 64'hFF8);
      chk("blt_we",   64'(rd_we), 64'd0);
      chk("blt_b",    opr_b, 64'd9);

      // JAL x1,+16, then the same with a wrapping target
      drive(32'h010000EF, 64'h2000, 64'h0, 64'h0);
      step();
      chk("jal_jmp", 64'(jmp), 64'd1);
      chk("jal_a",   opr_a, 64'h2000);
      chk("jal_b",   opr_b, 64'd4);
      chk("jal_tgt", tgt, 64'h2010);
      drive(32'h010000EF, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h0);
      step();
      chk("jal_wrap", tgt, 64'h8);

      // JALR x1,3(x2): low target bit cleared
      drive(32'h003100E7, 64'h3000, 64'h100, 64'h0);
      step();
      chk("jalr_tgt", tgt, 64'h102);
      chk("jalr_we",  64'(rd_we), 64'd1);

      // SD x2,8(x1)
      drive(32'h0020B423, 64'h0, 64'h100, 64'hDEAD);
      step();
      chk("sd_b",   opr_b, 64'd8);
      chk("sd_mem", 64'(mem_op), 64'd2);
      chk("sd_dat", store_data, 64'hDEAD);
      chk("sd_we",  64'(rd_we), 64'd0);

      // ADDI x0: no write
      drive(32'h00000013, 64'h0, 64'h0, 64'h0);
      step();
      chk("x0_we", 64'(rd_we), 64'd0);

      // SRAI x1,x2,33 uses the 6-bit shamt
      drive(32'h42115093, 64'h0, 64'h55, 64'h0);
      step();
      chk("srai_func", 64'(alu_func), 64'(OP_SRA));
      chk("srai_b",    opr_b, 64'd33);
      chk("srai_ill",  64'(illegal), 64'd0);

      // Illegal words
      drive(32'hFFFFFFFF, 64'h40, 64'h11, 64'h22);
      step();
      chk("ill_flag", 64'(illegal), 64'd1);
      chk("ill_we",   64'(rd_we), 64'd0);
      chk("ill_a",    opr_a, 64'd0);
      chk("ill_func", 64'(alu_func), 64'(OP_ADD));
      drive(32'h44515093, 64'h0, 64'h11, 64'h0);
      step();
      chk("srai_bad_ill", 64'(illegal), 64'd1);
      chk("srai_bad_we",  64'(rd_we), 64'd0);

      // Flush with a held bundle and a new one arriving
      out_ready = 1'b0;
      drive(32'hFFF10093, 64'h0, 64'd5, 64'd0);
      flush = 1'b1;
      step();
      chk("flush_valid", 64'(out_valid), 64'd0);
      flush = 1'b0; in_valid = 1'b0;
      step();
      chk("flush_drop", 64'(out_valid), 64'd0);

      // Reset in the middle of a stall
      in_valid = 1'b1;
      step();
      chk("hold_valid", 64'(out_valid), 64'd1);
      in_valid = 1'b0;
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_a",     opr_a, 64'd0);
      chk("arst_rd",    64'(rd), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
